bsg_link_ddr_reset_sequencer: RTL and testbench
===============================================

Name: bsg_link_ddr_reset_sequencer

Overview:
Single-clock controller that runs the bring-up and retrain reset sequence for one DDR IO link (upstream and downstream pair). It replaces the manual, per-bit tag writes to link resets with one start pulse. It drives the io-side up/down link resets, the async token reset and the core-side up/down link resets in the required order, holding each phase a programmable number of cycles. All outputs are glitch-free flops so that downstream bsg_sync_sync stages can safely cross them into the io, token and core clock domains.

Parameters:
wait_width_p, 8, width of the phase-hold count; maximum hold is 2^wait_width_p-1 cycles.
default_wait_p, 16, hold count used when cfg_wait_i==0 at start and cfg_override_i==0.

Ports:
clk_i  in  1  sequencer clock (tag or core clock); slowest link-domain clock at most 4x slower.
reset_n_i  in  1  reset; asynchronous, active-low.
start_i  in  1  single-cycle request; begins sequence from IDLE or DONE.
cfg_override_i  in  1  1: use cfg_wait_i; 0: use default_wait_p.
cfg_wait_i  in  wait_width_p  phase hold in cycles; sampled only on accepted start.
io_up_link_reset_o  out  1  uplink io_link_reset.
io_down_link_reset_o  out  1  downlink io reset, before per-channel sync.
async_token_reset_o  out  1  uplink async_token_reset.
core_up_link_reset_o  out  1  uplink core_link_reset.
core_down_link_reset_o  out  1  downlink core_link_reset.
busy_o  out  1  sequence in progress.
done_o  out  1  link released; stays high until restart or reset.
state_o  out  3  encoded state, for debug and tag readback.

Behaviour:
- Clocking and reset: one clock, clk_i. reset_n_i is asynchronous and active-low.
- While reset_n_i is low: state=IDLE; all four link resets=1; token=0; busy=0; done=0; counter=0.
- States and encoding: IDLE=0, RST_ALL=1, TOK_HI=2, TOK_LO=3, UP_IO=4, DN_IO=5, CORE=6, DONE=7.
- Output per state (registered; a value changes on the same edge the state changes):
  - IDLE and RST_ALL: all link resets 1, token 0.
  - TOK_HI: token 1, all link resets 1.
  - TOK_LO: token 0, all link resets 1.
  - UP_IO: io_up 0; io_down, core_up, core_down 1.
  - DN_IO: io_up 0, io_down 0, core resets 1.
  - CORE: all link resets 0.
  - DONE: all link resets 0, done=1.
- busy=1 in states 1-6.
- Start acceptance: start_i is accepted only in IDLE or DONE; it is ignored while busy (no queuing).
- Hold latching: on accept, W = cfg_override_i ? cfg_wait_i : default_wait_p. If W==0, W is forced to 1. W is latched into a register.
- Phase timing: on the accept edge the FSM enters RST_ALL and the counter loads W-1. Each of the phases RST_ALL..CORE lasts exactly W cycles. The FSM advances when the counter==0, and the counter reloads W-1 on each advance. DONE is entered 6W edges after the accept edge.
- Restart from DONE: start_i in DONE re-enters RST_ALL. done drops and all resets reassert on the same edge (retrain).
- Mid-sequence changes: changes to cfg_wait_i or cfg_override_i mid-sequence have no effect.
- Reset mid-sequence: assertion forces the reset values immediately, without waiting for an edge. After deassertion the FSM stays in IDLE until start_i.
- Ordering invariant (assert in the bench): token pulse precedes io_up release; io_up release precedes io_down; io_down precedes core releases. Core resets never deassert while any io reset is high.
- Counter arithmetic: width wait_width_p, decrement only, no wrap.

Decomposition:
- Shared package bsg_link_ddr_seq_pkg holds:
  - the state enum typedef bsg_link_ddr_seq_state_e (3 bits, encoding above);
  - a packed struct bsg_link_ddr_reset_s {io_up, io_down, token, core_up, core_down};
  - constant bsg_link_ddr_reset_all_c.
- One natural sub-module: bsg_link_ddr_seq_timer, a loadable down-counter with zero flag and W==0→1 clamp, reusable for other bring-up FSMs.
- The FSM and registered output decode stay in the top module.

Test Plan:
- Reset, then cfg_override=1, cfg_wait=3, pulse start at edge 0 → token high on edges 3-5; io_up falls at edge 9; io_down at edge 12; core resets at edge 15; done=1 at edge 18; busy low at edge 18.
- cfg_override=0, start → each phase holds 16 cycles; done at edge 96. Separately, cfg_override=1, cfg_wait=0 → behaves as W=1, done at edge 6.
- Second start at edge 4 of a W=3 run, plus cfg_wait changed to 10 mid-run → both ignored; done still at edge 18.
- In DONE, start with W=2 → done drops and all resets reassert on the accept edge; done returns at edge 12 after accept.
- reset_n_i low for 1 ns between edges while in DN_IO → outputs return to reset values immediately, no clock needed; remain in IDLE afterwards until start.
- W=255 run with a random-start soak → the ordering invariant holds throughout; state_o matches the phase at every edge.

Source files
------------

// File: rtl/bsg_link_ddr_seq_pkg.sv
// Shared types for the DDR link reset sequencer: state encoding, reset bundle
// and the per-state reset decode.
`timescale 1ns/1ps
package bsg_link_ddr_seq_pkg;

   typedef enum logic [2:0] {
      SEQ_IDLE    = 3'd0,
      SEQ_RST_ALL = 3'd1,
      SEQ_TOK_HI  = 3'd2,
      SEQ_TOK_LO  = 3'd3,
      SEQ_UP_IO   = 3'd4,
      SEQ_DN_IO   = 3'd5,
      SEQ_CORE    = 3'd6,
      SEQ_DONE    = 3'd7
   } bsg_link_ddr_seq_state_e;

   typedef struct packed {
      logic io_up;
      logic io_down;
      logic token;
      logic core_up;
      logic core_down;
   } bsg_link_ddr_reset_s;

   localparam bsg_link_ddr_reset_s bsg_link_ddr_reset_all_c = '{
      io_up: 1'b1, io_down: 1'b1, token: 1'b0, core_up: 1'b1, core_down: 1'b1
   };

   function automatic bsg_link_ddr_reset_s resets_for_state(bsg_link_ddr_seq_state_e s);
      bsg_link_ddr_reset_s r;
      r = bsg_link_ddr_reset_all_c;
      case (s)
         SEQ_TOK_HI: r.token = 1'b1;
         SEQ_UP_IO:  r.io_up = 1'b0;
         SEQ_DN_IO: begin
            r.io_up   = 1'b0;
            r.io_down = 1'b0;
         end
         SEQ_CORE, SEQ_DONE: r = '0;
         default: ;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/bsg_link_ddr_seq_timer.sv
// Loadable phase-hold down-counter: latches a hold count (0 clamped to 1),
// reloads hold-1 on request, decrements to zero without wrapping.
`timescale 1ns/1ps
module bsg_link_ddr_seq_timer #(
   parameter int width_p = 8
) (
   input  logic               clk_i,
   input  logic               reset_n_i,
   input  logic               start_i,
   input  logic [width_p-1:0] wait_i,
   input  logic               reload_i,
   input  logic               dec_i,
   output logic               zero_o
);

   logic [width_p-1:0] hold_q;
   logic [width_p-1:0] cnt_q;
   logic [width_p-1:0] hold_eff;

   always_comb begin
      hold_eff = (wait_i == '0) ? width_p'(1) : wait_i;
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         hold_q <= width_p'(1);
         cnt_q  <= '0;
      end else if (start_i) begin
         hold_q <= hold_eff;
         cnt_q  <= hold_eff - width_p'(1);
      end else if (reload_i) begin
         cnt_q <= hold_q - width_p'(1);
      end else if (dec_i && cnt_q != '0) begin
         cnt_q <= cnt_q - width_p'(1);
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/bsg_link_ddr_reset_sequencer.sv
// One-shot bring-up/retrain reset sequencer for a DDR IO link pair.
// state   | meaning
// IDLE    | after reset, waiting for start; everything held in reset
// RST_ALL | all link resets asserted for W cycles
// TOK_HI  | async token reset pulsed high
// TOK_LO  | token reset low again, link resets still held
// UP_IO   | uplink io reset released
// DN_IO   | downlink io reset released
// CORE    | core-side resets released
// DONE    | link up; done held until restart or reset
`timescale 1ns/1ps
module bsg_link_ddr_reset_sequencer
   import bsg_link_ddr_seq_pkg::*;
#(
   parameter int wait_width_p   = 8,
   parameter int default_wait_p = 16
) (
   input  logic                    clk_i,
   input  logic                    reset_n_i,
   input  logic                    start_i,
   input  logic                    cfg_override_i,
   input  logic [wait_width_p-1:0] cfg_wait_i,
   output logic                    io_up_link_reset_o,
   output logic                    io_down_link_reset_o,
   output logic                    async_token_reset_o,
   output logic                    core_up_link_reset_o,
   output logic                    core_down_link_reset_o,
   output logic                    busy_o,
   output logic                    done_o,
   output logic [2:0]              state_o
);

   bsg_link_ddr_seq_state_e state_q, state_n;
   bsg_link_ddr_reset_s     resets_q, resets_n;
   logic [wait_width_p-1:0] wait_sel;
   logic accept, in_phase, zero;

   always_comb begin
      wait_sel = cfg_override_i ? cfg_wait_i : wait_width_p'(default_wait_p);
      accept   = start_i && (state_q == SEQ_IDLE || state_q == SEQ_DONE);
      in_phase = (state_q != SEQ_IDLE) && (state_q != SEQ_DONE);
      state_n  = state_q;
      if (accept)
         state_n = SEQ_RST_ALL;
      else if (in_phase && zero)
         state_n = bsg_link_ddr_seq_state_e'(state_q + 3'd1);
      resets_n = resets_for_state(state_n);
   end

   bsg_link_ddr_seq_timer #(.width_p(wait_width_p)) timer (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .start_i   (accept),
      .wait_i    (wait_sel),
      .reload_i  (in_phase && zero),
      .dec_i     (in_phase && !zero),
      .zero_o    (zero)
   );

   // Outputs are decoded from the next state so they flop on the state edge.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q  <= SEQ_IDLE;
         resets_q <= bsg_link_ddr_reset_all_c;
         busy_o   <= 1'b0;
         done_o   <= 1'b0;
      end else begin
         state_q  <= state_n;
         resets_q <= resets_n;
         busy_o   <= (state_n != SEQ_IDLE) && (state_n != SEQ_DONE);
         done_o   <= (state_n == SEQ_DONE);
      end
   end

   assign io_up_link_reset_o     = resets_q.io_up;
   assign io_down_link_reset_o   = resets_q.io_down;
   assign async_token_reset_o    = resets_q.token;
   assign core_up_link_reset_o   = resets_q.core_up;
   assign core_down_link_reset_o = resets_q.core_down;
   assign state_o                = state_q;

endmodule

// File: tb/tb_bsg_link_ddr_reset_sequencer.sv
// Bench for the DDR link reset sequencer: phase-arithmetic reference model,
// per-cycle compare, ordering invariant and hand-computed timing pins.
`timescale 1ns/1ps
module tb_bsg_link_ddr_reset_sequencer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       cfg_override = 1'b0;
   logic [7:0] cfg_wait = 8'd0;
   logic io_up, io_down, token, core_up, core_down, busy, done;
   logic [2:0] state;

   int errors = 0;
   int checks = 0;
   int k = 0;

   always #5 clk = ~clk;

   bsg_link_ddr_reset_sequencer #(.wait_width_p(8), .default_wait_p(16)) dut (
      .clk_i                  (clk),
      .reset_n_i              (rst_n),
      .start_i                (start),
      .cfg_override_i         (cfg_override),
      .cfg_wait_i             (cfg_wait),
      .io_up_link_reset_o     (io_up),
      .io_down_link_reset_o   (io_down),
      .async_token_reset_o    (token),
      .core_up_link_reset_o   (core_up),
      .core_down_link_reset_o (core_down),
      .busy_o                 (busy),
      .done_o                 (done),
      .state_o                (state)
   );

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s t=%0t k=%0d got=%0h exp=%0h", name, $time, k, act, exp);
      end
   endtask

   // Reference model: a sequence is "edges since accept" divided into six
   // equal phases of W; past 6W it is done.
   bit m_active = 0, m_done = 0;
   int m_k = 0, m_w = 1;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_active = 0; m_done = 0; m_k = 0;
      end else if (!m_active && start) begin
         m_w = cfg_override ? ((cfg_wait == 0) ? 1 : int'(cfg_wait)) : 16;
         m_k = 0; m_active = 1; m_done = 0;
      end else if (m_active) begin
         m_k++;
         if (m_k == 6 * m_w) begin
            m_active = 0; m_done = 1;
         end
      end
   end

   function automatic int exp_state();
      if (m_active) return 1 + m_k / m_w;
      return m_done ? 7 : 0;
   endfunction

   function automatic logic [6:0] exp_outs(int s);
      return {s < 4, s < 5, s == 2, s < 6, s < 6, s >= 1 && s <= 6, s == 7};
   endfunction

   bit tok_seen = 0;
   logic prev_io_up = 1'b1;

   always @(negedge clk) begin
      int s;
      s = exp_state();
      chk("state", 32'(state), 32'(s));
      chk("outs", 32'({io_up, io_down, token, core_up, core_down, busy, done}), 32'(exp_outs(s)));
      if (token) tok_seen = 1;
      else if (io_up && !prev_io_up) tok_seen = 0;
      prev_io_up = io_up;
      if (!io_up)   chk("order_tok_before_io_up", 32'(tok_seen), 32'd1);
      if (!io_down) chk("order_io_up_before_down", 32'(io_up), 32'd0);
      if (!core_up || !core_down) chk("order_io_before_core", 32'({io_up, io_down}), 32'd0);
   end

   task automatic tick();
      @(posedge clk); #1; k++;
   endtask

   task automatic accept_start(bit ov, int w);
      cfg_override = ov; cfg_wait = 8'(w); start = 1'b1;
      @(posedge clk); #1;
      k = 0; start = 1'b0;
   endtask

   task automatic run_to(int n);
      while (k < n) tick();
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_outs", 32'({io_up, io_down, token, core_up, core_down, busy, done}), 32'b1101100);
      rst_n = 1'b1;
      repeat (2) tick();

      // W=3 from IDLE
      accept_start(1, 3);
      chk("a_state0", 32'(state), 32'd1);
      run_to(2);  chk("a_tok2", 32'(token), 32'd0);
      run_to(3);  chk("a_tok3", 32'(token), 32'd1);
      run_to(5);  chk("a_tok5", 32'(token), 32'd1);
      run_to(6);  chk("a_tok6", 32'(token), 32'd0);
      run_to(8);  chk("a_ioup8", 32'(io_up), 32'd1);
      run_to(9);  chk("a_ioup9", 32'(io_up), 32'd0);
      run_to(11); chk("a_iodn11", 32'(io_down), 32'd1);
      run_to(12); chk("a_iodn12", 32'(io_down), 32'd0);
      run_to(14); chk("a_core14", 32'({core_up, core_down}), 32'd3);
      run_to(15); chk("a_core15", 32'({core_up, core_down}), 32'd0);
      run_to(17); chk("a_done17", 32'({done, busy}), 32'b01);
      run_to(18); chk("a_done18", 32'({done, busy}), 32'b10);
      run_to(20);

      // Retrain from DONE with W=2
      accept_start(1, 2);
      chk("b_accept", 32'({done, io_up, io_down, core_up, core_down}), 32'b01111);
      run_to(11); chk("b_done11", 32'(done), 32'd0);
      run_to(12); chk("b_done12", 32'(done), 32'd1);

      // W=3 with an ignored second start and a mid-run cfg change
      accept_start(1, 3);
      run_to(3); start = 1'b1;
      tick();    start = 1'b0; cfg_wait = 8'd10;
      chk("c_state4", 32'(state), 32'd2);
      run_to(17); chk("c_done17", 32'(done), 32'd0);
      run_to(18); chk("c_done18", 32'(done), 32'd1);

      // Default hold of 16
      accept_start(0, 50);
      run_to(16); chk("d_state16", 32'(state), 32'd2);
      run_to(95); chk("d_done95", 32'(done), 32'd0);
      run_to(96); chk("d_done96", 32'(done), 32'd1);

      // W=0 behaves as W=1
      accept_start(1, 0);
      run_to(5); chk("e_state5", 32'(state), 32'd6);
      run_to(6); chk("e_done6", 32'(done), 32'd1);

      // Async reset in DN_IO, between edges
      accept_start(1, 5);
      run_to(22); chk("f_state22", 32'(state), 32'd5);
      #2 rst_n = 1'b0;
      #0.5;
      chk("f_async_state", 32'(state), 32'd0);
      chk("f_async_outs", 32'({io_up, io_down, token, core_up, core_down, busy, done}), 32'b1101100);
      #0.5 rst_n = 1'b1;
      repeat (5) tick();
      chk("f_stay_idle", 32'(state), 32'd0);

      // W=255 with random start/cfg noise while busy
      accept_start(1, 255);
      while (k < 6 * 255) begin
         start = (k < 1520) && ($urandom_range(0, 7) == 0);
         cfg_override = 1'($urandom);
         cfg_wait = 8'($urandom);
         tick();
      end
      start = 1'b0;
      chk("g_done", 32'(done), 32'd1);

      // Random soak with short holds
      for (int i = 0; i < 1500; i++) begin
         start = ($urandom_range(0, 9) == 0);
         cfg_override = ($urandom_range(0, 7) != 0);
         cfg_wait = 8'($urandom_range(0, 6));
         tick();
      end
      start = 1'b0;
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
